random_state_sequencer: RTL

- Synthesizable, run-time programmable controller that produces a random two-level activity pattern on `state_o`. The pattern alternates a state-0 phase and a state-1 phase, and each phase length is drawn from a programmed [min, max] range.
- Intended uses: valid/ready throttling, backpressure injection, and enable gating in FPGA-resident traffic generators, where simulation-only `$urandom_range` is unavailable.
- A host or upper FSM programs the ranges and the period count, issues `start_i`, and observes `busy_o`, `done_o` and `cfg_err_o`.

---
 rtl/random_state_pkg.sv | 22 ++
 rtl/lfsr_galois.sv | 31 +++
 rtl/random_state_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/random_state_pkg.sv
// Shared types, constants and the phase-length draw used by the random state sequencer.
package random_state_pkg;

  typedef enum logic [1:0] {IDLE, RUN0, RUN1} rsq_state_t;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // len = min + ((lfsr * span) >> lfsr_w); the scaled fraction stays below span, so len <= max.
  function automatic logic [31:0] draw_len(input logic [31:0] lfsr,
                                           input logic [31:0] min_v,
                                           input logic [31:0] max_v,
                                           input int unsigned lfsr_w);
    logic [32:0] span;
    logic [64:0] prod;
    span = {1'b0, max_v} - {1'b0, min_v} + 33'd1;
    prod = {33'd0, lfsr} * {32'd0, span};
    prod = prod >> lfsr_w;
    return min_v + prod[31:0];
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR; a load takes effect before an advance in the same cycle.
module lfsr_galois #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MASK  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             a_rst_n_i,
  input  logic             advance_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d, cur;

  always_comb begin
    // An all-zero state would lock up, so a zero seed falls back to SEED.
    cur = load_i ? ((load_val_i == '0) ? SEED : load_val_i) : lfsr_q;
    lfsr_d = cur;
    if (advance_i) lfsr_d = cur[0] ? ((cur >> 1) ^ MASK) : (cur >> 1);
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) lfsr_q <= SEED;
    else            lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/random_state_sequencer.sv
// Programmable two-level random activity generator: alternating state-0 / state-1
// phases whose lengths are drawn from [min, max] ranges by an LFSR.
module random_state_sequencer
  import random_state_pkg::*;
#(
  parameter int                CNT_W  = 16,
  parameter int                PER_W  = 16,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
  input  logic              clk_i,
  input  logic              a_rst_n_i,
  input  logic [CNT_W-1:0]  s0_min_i,
  input  logic [CNT_W-1:0]  s0_max_i,
  input  logic [CNT_W-1:0]  s1_min_i,
  input  logic [CNT_W-1:0]  s1_max_i,
  input  logic [PER_W-1:0]  periods_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              seed_load_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic              state_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              cfg_err_o
);

  rsq_state_t       state_q;
  logic [CNT_W-1:0] cnt_q, s0_min_q, s0_max_q, s1_min_q, s1_max_q;
  logic [PER_W-1:0] per_q, periods_q;
  logic             state_o_q, busy_q, done_q, err_q;

  logic [LFSR_W-1:0] lfsr_val, draw_src;
  logic [CNT_W-1:0]  dmin, dmax, len_d;
  logic [31:0]       draw_full;
  logic              cfg_ok, last, per_done, draw_en, seed_ld;
  logic              unused_draw_hi;

  always_comb begin
    cfg_ok   = (s0_min_i != '0) && (s0_min_i <= s0_max_i) &&
               (s1_min_i != '0) && (s1_min_i <= s1_max_i);
    last     = (cnt_q == '0);
    per_done = (periods_q != '0) && (per_q == periods_q - PER_W'(1));
    seed_ld  = (state_q == IDLE) && seed_load_i;
    draw_en  = 1'b0;
    draw_src = lfsr_val;
    dmin     = s0_min_q;
    dmax     = s0_max_q;
    case (state_q)
      IDLE: begin
        // A seed loaded alongside start feeds the very first draw.
        draw_en  = start_i && !stop_i && cfg_ok;
        draw_src = seed_load_i ? ((seed_i == '0) ? SEED : seed_i) : lfsr_val;
        dmin     = s0_min_i;
        dmax     = s0_max_i;
      end
      RUN0: begin
        draw_en = !stop_i && last;
        dmin    = s1_min_q;
        dmax    = s1_max_q;
      end
      RUN1: draw_en = !stop_i && last && !per_done;
      default: draw_en = 1'b0;
    endcase
    draw_full = draw_len(32'(draw_src), 32'(dmin), 32'(dmax), LFSR_W);
    len_d     = draw_full[CNT_W-1:0];
  end

  assign unused_draw_hi = ^draw_full[31:CNT_W];

  lfsr_galois #(
    .WIDTH (LFSR_W),
    .MASK  (LFSR_W'(LFSR_MASK)),
    .SEED  (SEED)
  ) u_lfsr (
    .clk_i      (clk_i),
    .a_rst_n_i  (a_rst_n_i),
    .advance_i  (draw_en),
    .load_i     (seed_ld),
    .load_val_i (seed_i),
    .value_o    (lfsr_val)
  );

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      per_q     <= '0;
      periods_q <= '0;
      s0_min_q  <= '0;
      s0_max_q  <= '0;
      s1_min_q  <= '0;
      s1_max_q  <= '0;
      state_o_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          state_o_q <= 1'b0;
          busy_q    <= 1'b0;
          if (start_i && !stop_i) begin
            s0_min_q  <= s0_min_i;
            s0_max_q  <= s0_max_i;
            s1_min_q  <= s1_min_i;
            s1_max_q  <= s1_max_i;
            periods_q <= periods_i;
            if (cfg_ok) begin
              state_q <= RUN0;
              cnt_q   <= len_d - CNT_W'(1);
              per_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN0: begin
          if (stop_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            state_o_q <= 1'b0;
          end else if (last) begin
            state_q   <= RUN1;
            cnt_q     <= len_d - CNT_W'(1);
            state_o_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RUN1: begin
          if (stop_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            state_o_q <= 1'b0;
          end else if (last) begin
            state_o_q <= 1'b0;
            if (per_done) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN0;
              cnt_q   <= len_d - CNT_W'(1);
              // Endless runs keep the period count pinned at zero.
              if (periods_q != '0) per_q <= per_q + PER_W'(1);
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_o   = state_o_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign cfg_err_o = err_q;

endmodule
